// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: C_NUM_REGS 32-bit registers, each R/W (driven to fabric) or RO
// (sampled from fabric), with byte strobes, SLVERR on illegal accesses and per-register pulses.
module axi_lite_regbank #(
   parameter int unsigned          C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned          C_NUM_REGS         = 16,
   parameter int unsigned          C_S_AXI_ADDR_WIDTH = 6,
   parameter logic [C_NUM_REGS-1:0] C_RO_MASK         = '0
) (
   input  logic                                         S_AXI_ACLK,
   input  logic                                         S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
   input  logic [2:0]                                   S_AXI_AWPROT,
   input  logic                                         S_AXI_AWVALID,
   output logic                                         S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
   input  logic                                         S_AXI_WVALID,
   output logic                                         S_AXI_WREADY,
   output logic [1:0]                                   S_AXI_BRESP,
   output logic                                         S_AXI_BVALID,
   input  logic                                         S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
   input  logic [2:0]                                   S_AXI_ARPROT,
   input  logic                                         S_AXI_ARVALID,
   output logic                                         S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
   output logic [1:0]                                   S_AXI_RRESP,
   output logic                                         S_AXI_RVALID,
   input  logic                                         S_AXI_RREADY,
   output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]     reg_out,
   input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]     reg_in,
   output logic [C_NUM_REGS-1:0]                        wr_pulse,
   output logic [C_NUM_REGS-1:0]                        rd_pulse
);

   localparam int unsigned DW          = C_S_AXI_DATA_WIDTH;
   localparam int unsigned NB          = DW / 8;
   localparam int unsigned IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
      $fatal(1, "axi_lite_regbank: only 32-bit data is supported");
   end
   if (C_NUM_REGS == 0 || C_NUM_REGS > 64) begin : g_bad_num_regs
      $fatal(1, "axi_lite_regbank: C_NUM_REGS must be 1..64");
   end
   if (C_S_AXI_ADDR_WIDTH < $clog2(C_NUM_REGS) + 2) begin : g_bad_addr_width
      $fatal(1, "axi_lite_regbank: C_S_AXI_ADDR_WIDTH too small for C_NUM_REGS");
   end

   // live_q keeps the READY outputs low until the first edge after reset release.
   logic                  live_q, live_d;
   logic                  aw_held_q, aw_held_d;
   logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
   logic                  w_held_q, w_held_d;
   logic [DW-1:0]         w_data_q, w_data_d;
   logic [NB-1:0]         w_strb_q, w_strb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [DW-1:0]         rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DW-1:0]         regs_q [C_NUM_REGS];
   logic [DW-1:0]         regs_d [C_NUM_REGS];
   logic [C_NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
   logic [C_NUM_REGS-1:0] rd_pulse_q, rd_pulse_d;

   logic             awready, wready, arready;
   logic             aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0] ar_idx;

   assign awready = live_q & ~aw_held_q & ~bvalid_q;
   assign wready  = live_q & ~w_held_q & ~bvalid_q;
   assign arready = live_q & ~rvalid_q;
   assign aw_hs   = S_AXI_AWVALID & awready;
   assign w_hs    = S_AXI_WVALID & wready;
   assign ar_hs   = S_AXI_ARVALID & arready;
   assign commit  = aw_held_q & w_held_q;
   assign ar_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

   always_comb begin
      live_d     = 1'b1;
      aw_held_d  = aw_held_q;
      aw_idx_d   = aw_idx_q;
      w_held_d   = w_held_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      regs_d     = regs_q;
      wr_pulse_d = '0;
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = RESP_SLVERR;
         for (int i = 0; i < int'(C_NUM_REGS); i++) begin
            if (aw_idx_q == IDX_W'(i) && !C_RO_MASK[i]) begin
               bresp_d       = RESP_OKAY;
               wr_pulse_d[i] = 1'b1;
               for (int k = 0; k < int'(NB); k++) begin
                  if (w_strb_q[k]) begin
                     regs_d[i][8*k +: 8] = w_data_q[8*k +: 8];
                  end
               end
            end
         end
      end else if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end
   end

   // Reads sample regs_q, so a read racing a commit to the same register sees the old value.
   always_comb begin
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rd_pulse_d = '0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = RESP_SLVERR;
         for (int i = 0; i < int'(C_NUM_REGS); i++) begin
            if (ar_idx == IDX_W'(i)) begin
               rresp_d       = RESP_OKAY;
               rd_pulse_d[i] = 1'b1;
               rdata_d       = C_RO_MASK[i] ? reg_in[i*DW +: DW] : regs_q[i];
            end
         end
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         live_q     <= 1'b0;
         aw_held_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         regs_q     <= '{default: '0};
         wr_pulse_q <= '0;
         rd_pulse_q <= '0;
      end else begin
         live_q     <= live_d;
         aw_held_q  <= aw_held_d;
         aw_idx_q   <= aw_idx_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         regs_q     <= regs_d;
         wr_pulse_q <= wr_pulse_d;
         rd_pulse_q <= rd_pulse_d;
      end
   end

   for (genvar g = 0; g < int'(C_NUM_REGS); g++) begin : g_reg_out
      assign reg_out[g*DW +: DW] = C_RO_MASK[g] ? '0 : regs_q[g];
   end

   assign S_AXI_AWREADY = awready;
   assign S_AXI_WREADY  = wready;
   assign S_AXI_ARREADY = arready;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign wr_pulse      = wr_pulse_q;
   assign rd_pulse      = rd_pulse_q;

   // PROT and the byte offset never affect the bank; R/W slices of reg_in are ignored.
   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                            reg_in};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Randomised + directed bench for axi_lite_regbank with a cycle-level transaction model
// checked against every DUT output on each falling clock edge.
module tb_axi_lite_regbank;
   localparam int unsigned     NR     = 16;
   localparam int unsigned     AW     = 7;
   localparam logic [NR-1:0]   RO     = 16'h1020;
   localparam logic [1:0]      OKAY   = 2'b00;
   localparam logic [1:0]      SLVERR = 2'b10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [AW-1:0]     awaddr = '0;
   logic [2:0]        awprot = '0;
   logic              awvalid = 1'b0;
   logic              awready;
   logic [31:0]       wdata = '0;
   logic [3:0]        wstrb = '0;
   logic              wvalid = 1'b0;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready = 1'b1;
   logic [AW-1:0]     araddr = '0;
   logic [2:0]        arprot = '0;
   logic              arvalid = 1'b0;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready = 1'b1;
   logic [NR*32-1:0]  reg_out;
   logic [NR*32-1:0]  reg_in = '0;
   logic [NR-1:0]     wr_pulse;
   logic [NR-1:0]     rd_pulse;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_lite_regbank #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_NUM_REGS         (NR),
      .C_S_AXI_ADDR_WIDTH (AW),
      .C_RO_MASK          (RO)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_out       (reg_out),
      .reg_in        (reg_in),
      .wr_pulse      (wr_pulse),
      .rd_pulse      (rd_pulse)
   );

   task automatic check(input string name, input logic [NR*32-1:0] got,
                        input logic [NR*32-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s got timeout exp handshake", name);
   endtask

   // ---------------- reference model ----------------
   logic [31:0]  mregs [NR];
   int unsigned  aw_pend[$];
   logic [35:0]  w_pend[$];
   bit           m_live, m_bv, m_rv;
   logic [1:0]   m_br, m_rr;
   logic [31:0]  m_rd;
   logic [NR-1:0] m_wrp, m_rdp;
   bit           e_awr, e_wr, e_arr;
   int unsigned  m_idx;
   logic [35:0]  m_w;
   logic [31:0]  m_mask;

   function automatic logic [NR*32-1:0] model_flat();
      logic [NR*32-1:0] f;
      f = '0;
      for (int i = 0; i < NR; i++) if (!RO[i]) f[i*32 +: 32] = mregs[i];
      return f;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_awready", awready, 0);
         check("rst_wready", wready, 0);
         check("rst_arready", arready, 0);
         check("rst_bvalid", bvalid, 0);
         check("rst_rvalid", rvalid, 0);
         check("rst_bresp", bresp, 0);
         check("rst_rresp", rresp, 0);
         check("rst_rdata", rdata, 0);
         check("rst_pulses", {wr_pulse, rd_pulse}, 0);
         check("rst_reg_out", reg_out, 0);
         for (int i = 0; i < NR; i++) mregs[i] = '0;
         aw_pend.delete();
         w_pend.delete();
         m_live = 0; m_bv = 0; m_rv = 0; m_br = OKAY; m_rr = OKAY; m_rd = '0;
         m_wrp = '0; m_rdp = '0;
      end else begin
         e_awr = m_live && aw_pend.size() == 0 && !m_bv;
         e_wr  = m_live && w_pend.size() == 0 && !m_bv;
         e_arr = m_live && !m_rv;
         check("awready", awready, e_awr);
         check("wready", wready, e_wr);
         check("arready", arready, e_arr);
         check("bvalid", bvalid, m_bv);
         if (m_bv) check("bresp", bresp, m_br);
         check("rvalid", rvalid, m_rv);
         if (m_rv) begin
            check("rdata", rdata, m_rd);
            check("rresp", rresp, m_rr);
         end
         check("wr_pulse", wr_pulse, m_wrp);
         check("rd_pulse", rd_pulse, m_rdp);
         check("reg_out", reg_out, model_flat());
         // Predict state after the coming rising edge.
         m_wrp = '0;
         m_rdp = '0;
         if (arvalid && e_arr) begin
            m_idx = int'(araddr) / 4;
            m_rv  = 1;
            if (m_idx < NR) begin
               m_rr = OKAY;
               m_rd = RO[m_idx] ? reg_in[m_idx*32 +: 32] : mregs[m_idx];
               m_rdp[m_idx] = 1'b1;
            end else begin
               m_rr = SLVERR;
               m_rd = '0;
            end
         end else if (m_rv && rready) begin
            m_rv = 0;
         end
         if (aw_pend.size() > 0 && w_pend.size() > 0) begin
            m_idx = aw_pend.pop_front();
            m_w   = w_pend.pop_front();
            m_bv  = 1;
            if (m_idx < NR && !RO[m_idx]) begin
               m_mask = {{8{m_w[35]}}, {8{m_w[34]}}, {8{m_w[33]}}, {8{m_w[32]}}};
               mregs[m_idx] = (mregs[m_idx] & ~m_mask) | (m_w[31:0] & m_mask);
               m_wrp[m_idx] = 1'b1;
               m_br = OKAY;
            end else begin
               m_br = SLVERR;
            end
         end else if (m_bv && bready) begin
            m_bv = 0;
         end
         if (awvalid && e_awr) aw_pend.push_back(int'(awaddr) / 4);
         if (wvalid && e_wr) w_pend.push_back({wstrb, wdata});
         m_live = 1;
      end
   end

   int wr_cnt [NR] = '{default: 0};
   int rd_cnt [NR] = '{default: 0};
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NR; i++) begin
            if (wr_pulse[i]) wr_cnt[i]++;
            if (rd_pulse[i]) rd_cnt[i]++;
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send_aw(input logic [AW-1:0] a, input int dly);
      int n;
      repeat (dly + 1) @(posedge clk);
      #1;
      awaddr  = a;
      awprot  = 3'($urandom);
      awvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!awready && n < 50);
      if (!awready) timeout("aw_handshake");
      @(posedge clk);
      #1 awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
      int n;
      repeat (dly + 1) @(posedge clk);
      #1;
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 50);
      if (!wready) timeout("w_handshake");
      @(posedge clk);
      #1 wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [AW-1:0] a);
      int n;
      @(posedge clk);
      #1;
      araddr  = a;
      arprot  = 3'($urandom);
      arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 50);
      if (!arready) timeout("ar_handshake");
      @(posedge clk);
      #1 arvalid = 1'b0;
   endtask

   // lat counts falling edges from the last address/data handshake to the first valid response.
   task automatic wait_b(output logic [1:0] resp, output int lat);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bvalid && lat < 50);
      if (!bvalid) timeout("b_response");
      resp = bresp;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_r(output logic [31:0] d, output logic [1:0] resp, output int lat);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rvalid && lat < 50);
      if (!rvalid) timeout("r_response");
      d    = rdata;
      resp = rresp;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat);
      fork
         send_aw(a, aw_dly);
         send_w(d, s, w_dly);
      join
      wait_b(resp, lat);
   endtask

   task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
      send_ar(a);
      wait_r(d, resp, lat);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   logic [1:0]  rs, ws;
   logic [31:0] rd;
   int          lat, rlat;

   initial begin
      reg_in[5*32 +: 32]  = 32'hCAFE_F00D;
      reg_in[12*32 +: 32] = 32'h0BAD_BEEF;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("release_awready_first", awready, 0);
      @(negedge clk);
      check("release_awready_next", awready, 1);

      for (int i = 0; i < 4; i++) begin
         do_write(AW'(i * 4), 32'(i + 1), 4'hF, 0, 0, ws, lat);
         check($sformatf("wr%0d_bresp", i), ws, OKAY);
      end
      for (int i = 0; i < 4; i++) begin
         do_read(AW'(i * 4), rd, rs, rlat);
         check($sformatf("rd%0d_data", i), rd, 32'(i + 1));
         check($sformatf("rd%0d_rresp", i), rs, OKAY);
         check($sformatf("wr%0d_pulse_count", i), wr_cnt[i], 1);
      end
      check("read_latency", rlat, 1);

      do_write(7'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, ws, lat);
      do_write(7'h08, 32'h1234_5678, 4'b0101, 0, 0, ws, lat);
      do_read(7'h08, rd, rs, rlat);
      check("strobe_rdata", rd, 32'hFF34_FF78);
      check("strobe_reg_out", reg_out[2*32 +: 32], 32'hFF34_FF78);

      do_write(7'h1C, 32'hA5A5_0007, 4'hF, 3, 0, ws, lat);
      check("w_first_latency", lat, 2);
      do_write(7'h20, 32'h5A5A_0008, 4'hF, 0, 0, ws, lat);
      check("same_cycle_latency", lat, 2);
      do_write(7'h24, 32'h0000_0909, 4'hF, 0, 2, ws, lat);
      check("aw_first_latency", lat, 2);
      do_read(7'h1F, rd, rs, rlat);
      check("w_first_rdata_offset_ignored", rd, 32'hA5A5_0007);
      do_read(7'h20, rd, rs, rlat);
      check("same_cycle_rdata", rd, 32'h5A5A_0008);

      do_write(7'h14, 32'h1111_2222, 4'hF, 0, 0, ws, lat);
      check("ro_write_bresp", ws, SLVERR);
      check("ro_write_no_pulse", wr_cnt[5], 0);
      do_read(7'h14, rd, rs, rlat);
      check("ro_rdata", rd, 32'hCAFE_F00D);
      check("ro_rresp", rs, OKAY);
      check("ro_rd_pulse_count", rd_cnt[5], 1);
      do_read(7'h30, rd, rs, rlat);
      check("ro12_rdata", rd, 32'h0BAD_BEEF);

      do_write(7'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, ws, lat);
      check("oor_bresp", ws, SLVERR);
      do_read(7'h40, rd, rs, rlat);
      check("oor_rdata", rd, 0);
      check("oor_rresp", rs, SLVERR);

      // Stall both response channels, then reset in the middle of the stall.
      bready = 1'b0;
      rready = 1'b0;
      fork
         send_aw(7'h0C, 0);
         send_w(32'h5555_AAAA, 4'hF, 0);
         send_ar(7'h08);
      join
      @(posedge clk);
      #1;
      repeat (10) begin
         @(negedge clk);
         check("hold_bvalid", bvalid, 1);
         check("hold_bresp", bresp, OKAY);
         check("hold_awready", awready, 0);
         check("hold_wready", wready, 0);
         check("hold_arready", arready, 0);
         check("hold_rvalid", rvalid, 1);
         check("hold_rdata", rdata, 32'hFF34_FF78);
         check("hold_reg3", reg_out[3*32 +: 32], 32'h5555_AAAA);
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("midreset_bvalid", bvalid, 0);
      check("midreset_rvalid", rvalid, 0);
      check("midreset_reg_out", reg_out, 0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      bready = 1'b1;
      rready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_read(AW'(i * 4), rd, rs, rlat);
         check($sformatf("post_reset_reg%0d", i), rd, 0);
      end

      // Random mixed traffic, reads and writes overlapping, including out-of-range indices.
      for (int it = 0; it < 250; it++) begin
         logic [AW-1:0] wa, ra;
         logic [31:0]   wd;
         logic [3:0]    st;
         int            op, awd, wdl;
         for (int i = 0; i < NR; i++) reg_in[i*32 +: 32] = $urandom;
         wa  = AW'({$urandom_range(0, 19), 2'($urandom)});
         ra  = AW'({$urandom_range(0, 19), 2'($urandom)});
         wd  = $urandom;
         st  = 4'($urandom);
         op  = $urandom_range(0, 2);
         awd = $urandom_range(0, 3);
         wdl = $urandom_range(0, 3);
         if (op == 0) begin
            do_write(wa, wd, st, awd, wdl, ws, lat);
         end else if (op == 1) begin
            do_read(ra, rd, rs, rlat);
         end else begin
            fork
               do_write(wa, wd, st, awd, wdl, ws, lat);
               do_read(ra, rd, rs, rlat);
            join
         end
      end
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
